// File: rtl/pipe_trace_pkg.sv
// rtl/pipe_trace_pkg.sv - shared types and widths for the pipeline trace buffer
package pipe_trace_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP      = 2'd0,
    MODE_STOP_FULL = 2'd1,
    MODE_TRIGGER   = 2'd2,
    MODE_RSVD      = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int TRACE_DATA_W = 32;

  function automatic int entry_w(int data_w);
    return 3 * data_w + 3;
  endfunction

  localparam int ENTRY_W = entry_w(TRACE_DATA_W);

  typedef struct packed {
    logic                    flush;
    logic                    branch;
    logic                    memwrite;
    logic [TRACE_DATA_W-1:0] alu;
    logic [TRACE_DATA_W-1:0] instr;
    logic [TRACE_DATA_W-1:0] pc;
  } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - DEPTH x W storage, synchronous write, asynchronous read
module trace_ram #(
  parameter int W     = 99,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_trace_buffer.sv
// rtl/pipe_trace_buffer.sv - stall-qualified pipeline trace capture with wrap/stop/trigger modes
module pipe_trace_buffer
  import pipe_trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int EW    = entry_w(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] trig_pc,
  input  logic [AW:0]       post_cnt,
  input  logic              cap_en,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] alu,
  input  logic              memwrite,
  input  logic              branch,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [EW-1:0]     rd_data,
  output logic [AW:0]       count,
  output logic [1:0]        state,
  output logic              triggered,
  output logic              overflow
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [DATA_W-1:0] trig_pc_q, trig_pc_d;
  logic [AW:0]       post_cnt_q, post_cnt_d;
  logic [AW:0]       post_q, post_d;
  logic [AW:0]       count_q, count_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              triggered_q, triggered_d;
  logic              overflow_q, overflow_d;
  logic              we, trig_hit;
  logic [EW-1:0]     wdata;

  assign wdata    = {flush, branch, memwrite, alu, instr, pc};
  assign we       = ~arm & cap_en & ~stall & (state_q == ST_ARMED || state_q == ST_POST);
  // Flushed instructions never trigger, and only the pre-trigger phase can fire.
  assign trig_hit = (mode_q == MODE_TRIGGER) && (state_q == ST_ARMED) && (pc == trig_pc_q) && ~flush;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    trig_pc_d   = trig_pc_q;
    post_cnt_d  = post_cnt_q;
    post_d      = post_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    triggered_d = triggered_q;
    overflow_d  = overflow_q;
    if (arm) begin
      state_d     = ST_ARMED;
      mode_d      = (mode == MODE_RSVD) ? MODE_WRAP : mode_e'(mode);
      trig_pc_d   = trig_pc;
      post_cnt_d  = post_cnt;
      post_d      = '0;
      count_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      triggered_d = 1'b0;
      overflow_d  = 1'b0;
    end else begin
      if (we) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        // Full buffer drops its oldest entry to make room.
        if (count_q == FULL) begin
          rd_ptr_d   = rd_ptr_q + 1'b1;
          overflow_d = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
        case (mode_q)
          MODE_STOP_FULL: if (count_q == FULL - ONE) state_d = ST_DONE;
          MODE_TRIGGER: begin
            if (state_q == ST_POST) begin
              post_d = post_q - ONE;
              if (post_q == ONE) state_d = ST_DONE;
            end else if (trig_hit) begin
              triggered_d = 1'b1;
              post_d      = post_cnt_q;
              state_d     = (post_cnt_q == '0) ? ST_DONE : ST_POST;
            end
          end
          default: ;
        endcase
      end
      if (state_q == ST_DONE && count_q != '0 && rd_ready) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        count_d  = count_q - ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_WRAP;
      trig_pc_q   <= '0;
      post_cnt_q  <= '0;
      post_q      <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      triggered_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      trig_pc_q   <= trig_pc_d;
      post_cnt_q  <= post_cnt_d;
      post_q      <= post_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      triggered_q <= triggered_d;
      overflow_q  <= overflow_d;
    end
  end

  trace_ram #(.W(EW), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign rd_valid  = (state_q == ST_DONE) && (count_q != '0);
  assign count     = count_q;
  assign state     = state_q;
  assign triggered = triggered_q;
  assign overflow  = overflow_q;

endmodule
